add_sub_acc: RTL and testbench
==============================

ADD_SUB_ACC -- requirements
Module: add_sub_acc

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, the operand and result width in bits (two's complement), legal range 4..64.
REQ-002 The block SHALL have parameter SAT, default 0; 0 gives a wrapping result, 1 clamps to the signed max/min on overflow.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port A, input, WIDTH bits: first operand (signed).
REQ-006 The block SHALL have port B, input, WIDTH bits: second operand (signed), ignored in accumulate ops.
REQ-007 The block SHALL have port op, input, 2 bits: 00 A+B, 01 A-B, 10 acc+A, 11 acc-A.
REQ-008 The block SHALL have port in_valid, input, 1 bit: A/B/op are valid this cycle.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-010 The block SHALL have port acc_clr, input, 1 bit: clear the accumulator and the sticky flag.
REQ-011 The block SHALL have port result, output, WIDTH bits: registered result.
REQ-012 The block SHALL have port overflow, output, 1 bit: signed overflow of the operation presented on result.
REQ-013 The block SHALL have port out_valid, output, 1 bit: result/overflow hold a valid operation.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the consumer accepts result this cycle.
REQ-015 The block SHALL have port ovf_sticky, output, 1 bit: set by any accepted overflowing operation since the last clear.
REQ-016 The block SHALL have port acc, output, WIDTH bits: current accumulator value.

Function
REQ-017 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL equal (!out_valid || out_ready), a combinational single-entry output stage, giving full throughput under no backpressure.
REQ-019 Latency SHALL be 1 cycle: an op accepted at edge N appears on result/overflow with out_valid=1 after edge N.
REQ-020 While out_valid=1 and out_ready=0, result, overflow and out_valid SHALL hold stable.
REQ-021 out_valid SHALL clear after an edge with out_ready=1 and no new transfer.
REQ-022 Each op SHALL compute the raw value using operands P,Q with modulo 2^WIDTH arithmetic: P=A,Q=B for ops 00/01; P=acc,Q=A for ops 10/11.
REQ-023 For add, overflow SHALL be sign(P)==sign(Q) and sign(raw)!=sign(P).
REQ-024 For subtract, overflow SHALL be sign(P)!=sign(Q) and sign(raw)!=sign(P).
REQ-025 With SAT=0, result SHALL be raw.
REQ-026 With SAT=1 and overflow, result SHALL be 0111..1 if sign(P)=0, else 1000..0; overflow still reports 1.
REQ-027 For ops 10/11, acc SHALL load the (possibly saturated) result on the accepting edge.
REQ-028 Ops 00/01 SHALL NOT modify acc.
REQ-029 ovf_sticky SHALL set on any accepting edge whose overflow=1; it is cleared only by acc_clr or reset.
REQ-030 acc_clr=1 SHALL set acc to 0 and ovf_sticky to 0 on that edge, independent of handshake.
REQ-031 When acc_clr is simultaneous with an accepted op 10/11, the op SHALL use acc=0; acc and ovf_sticky then take that op's result and overflow (clear then operate).
REQ-032 When acc_clr is simultaneous with an accepted op 00/01, the op SHALL complete normally.
REQ-033 No state machine beyond the out_valid bit SHALL exist; there is no internal queue and no op is dropped or duplicated.

Reset
REQ-034 On an edge with rst_n=0: out_valid=0, result=0, overflow=0, acc=0, ovf_sticky=0; any in-flight result is discarded.
REQ-035 in_ready SHALL read 1 while rst_n=0 and SHALL NOT signal a transfer; inputs are ignored during reset.
REQ-036 The first transfer SHALL be possible on the first edge with rst_n=1.

Verification (WIDTH=16)
REQ-037 Bench SHALL check: op=00, A=0x7FFF, B=0x0001 -> result 0x8000, overflow=1 (SAT=0); with SAT=1 -> 0x7FFF, overflow=1, ovf_sticky=1.
REQ-038 Bench SHALL check: op=01, A=0x8000, B=0x0001 -> 0x7FFF, overflow=1 (SAT=0); with SAT=1 -> 0x8000; op=01, A=5, B=7 -> 0xFFFE, overflow=0.
REQ-039 Bench SHALL check: acc_clr, then op=10 with A=3, then op=10 A=3, then op=11 A=10 -> acc 3, 6, 0xFFFC; results match per cycle.
REQ-040 Bench SHALL check: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result stable; release -> one op per cycle, no loss or duplication vs reference model.
REQ-041 Bench SHALL check: acc=0x0010, acc_clr=1 together with accepted op=10 A=2 -> acc=0x0002, ovf_sticky=0.
REQ-042 Bench SHALL check: rst_n=0 asserted while out_valid=1 and acc=0x1234 -> next edge out_valid=0, acc=0, ovf_sticky=0.

Source files
------------

// File: rtl/add_sub_acc.sv
// Signed add/subtract unit with a running accumulator and a single-entry
// registered output stage (valid/ready), optional saturation on overflow.
module add_sub_acc #(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc
);

  localparam logic [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;
  logic [WIDTH-1:0] r_acc;
  logic             r_sticky;

  logic             w_in_ready;
  logic             w_xfer;
  logic             w_acc_op;
  logic             w_sub;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_raw;
  logic             w_sp;
  logic             w_sq;
  logic             w_sr;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  // Ready is forced high in reset, but no transfer is allowed then.
  assign w_in_ready = !rst_n || !r_out_valid || out_ready;
  assign w_xfer     = rst_n && in_valid && w_in_ready;

  assign w_acc_op   = op[1];
  assign w_sub      = op[0];

  // A same-cycle clear makes the accumulate op start from zero.
  assign w_acc_base = acc_clr ? '0 : r_acc;

  always_comb begin
    w_p = A;
    w_q = B;
    if (w_acc_op) begin
      w_p = w_acc_base;
      w_q = A;
    end
  end

  always_comb begin
    w_raw = w_p + w_q;
    if (w_sub) begin
      w_raw = w_p - w_q;
    end
  end

  assign w_sp = w_p[WIDTH-1];
  assign w_sq = w_q[WIDTH-1];
  assign w_sr = w_raw[WIDTH-1];

  always_comb begin
    w_ovf = 1'b0;
    unique case (1'b1)
      w_sub:  w_ovf = (w_sp != w_sq) && (w_sr != w_sp);
      !w_sub: w_ovf = (w_sp == w_sq) && (w_sr != w_sp);
    endcase
  end

  always_comb begin
    w_res = w_raw;
    if (SAT && w_ovf) begin
      w_res = w_sp ? SMIN : SMAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_overflow  <= w_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Clear first, then let an accepted op overwrite acc and the flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_xfer && w_acc_op) begin
        r_acc <= w_res;
      end else if (acc_clr) begin
        r_acc <= '0;
      end
      if (w_xfer && w_ovf) begin
        r_sticky <= 1'b1;
      end else if (acc_clr) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign result     = r_result;
  assign overflow   = r_overflow;
  assign out_valid  = r_out_valid;
  assign ovf_sticky = r_sticky;
  assign acc        = r_acc;

endmodule

// File: tb/tb_add_sub_acc.sv
// Scoreboard bench: wrapping and saturating instances driven in lockstep,
// directed vectors with hand-computed results.
module tb_add_sub_acc;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   op;
  logic         in_valid;
  logic         acc_clr;
  logic         out_ready;

  logic         in_ready0, in_ready1;
  logic [W-1:0] res0, res1;
  logic         ovf0, ovf1;
  logic         ov0, ov1;
  logic         stk0, stk1;
  logic [W-1:0] acc0, acc1;

  add_sub_acc #(.WIDTH(W), .SAT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op),
    .in_valid(in_valid), .in_ready(in_ready0),
    .acc_clr(acc_clr), .result(res0), .overflow(ovf0),
    .out_valid(ov0), .out_ready(out_ready),
    .ovf_sticky(stk0), .acc(acc0)
  );

  add_sub_acc #(.WIDTH(W), .SAT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op),
    .in_valid(in_valid), .in_ready(in_ready1),
    .acc_clr(acc_clr), .result(res1), .overflow(ovf1),
    .out_valid(ov1), .out_ready(out_ready),
    .ovf_sticky(stk1), .acc(acc1)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   total = 0;
  int   bad = 0;
  int   pushed = 0;
  int   popped0 = 0;
  int   popped1 = 0;
  int   t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov0 && out_ready) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb0_extra: got %0h want none", res0);
      end else begin
        e0 = q0.pop_front();
        chk("sb0_res", 32'(res0), 32'(e0.res));
        chk("sb0_ovf", 32'(ovf0), 32'(e0.ovf));
        popped0++;
      end
    end
    if (rst_n && ov1 && out_ready) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb1_extra: got %0h want none", res1);
      end else begin
        e1 = q1.pop_front();
        chk("sb1_res", 32'(res1), 32'(e1.res));
        chk("sb1_ovf", 32'(ovf1), 32'(e1.ovf));
        popped1++;
      end
    end
  end

  // Called at posedge+1; leaves in_valid high so ops can go back-to-back.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic clr,
                       input logic [W-1:0] r0, input logic v0,
                       input logic [W-1:0] r1, input logic v1,
                       output int tries);
    bit done;
    done = 1'b0;
    tries = 0;
    op = o;
    A = a;
    B = b;
    acc_clr = clr;
    in_valid = 1'b1;
    while (!done && tries < 20) begin
      tries++;
      @(negedge clk);
      if (in_ready0) begin
        q0.push_back(exp_t'{res: r0, ovf: v0});
        q1.push_back(exp_t'{res: r1, ovf: v1});
        pushed++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    acc_clr = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got no accept want accept");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a;
    rst_n = 1'b0;
    in_valid = 1'b0;
    acc_clr = 1'b0;
    out_ready = 1'b1;
    op = 2'b00;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(ov0), 32'(0));
    chk("rst_res", 32'(res0), 32'(0));
    chk("rst_acc", 32'(acc0), 32'(0));
    chk("rst_stk", 32'(stk0), 32'(0));
    chk("rst_rdy", 32'(in_ready0), 32'(1));
    rst_n = 1'b1;

    // wrap vs saturate on add and subtract overflow
    issue(2'b00, 16'h7FFF, 16'h0001, 0, 16'h8000, 1, 16'h7FFF, 1, t);
    chk("first_xfer", 32'(t), 32'(1));
    chk("stk0_add", 32'(stk0), 32'(1));
    chk("stk1_add", 32'(stk1), 32'(1));
    issue(2'b01, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 16'h8000, 1, t);
    issue(2'b01, 16'h0005, 16'h0007, 0, 16'hFFFE, 0, 16'hFFFE, 0, t);
    idle();

    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    chk("clr_acc", 32'(acc0), 32'(0));
    chk("clr_stk", 32'(stk0), 32'(0));

    // accumulate sequence
    issue(2'b10, 16'h0003, 16'h0000, 0, 16'h0003, 0, 16'h0003, 0, t);
    chk("acc_3", 32'(acc0), 32'(16'h0003));
    issue(2'b10, 16'h0003, 16'h0000, 0, 16'h0006, 0, 16'h0006, 0, t);
    chk("acc_6", 32'(acc0), 32'(16'h0006));
    issue(2'b11, 16'h000A, 16'h0000, 0, 16'hFFFC, 0, 16'hFFFC, 0, t);
    chk("acc_fffc", 32'(acc0), 32'(16'hFFFC));
    chk("acc1_fffc", 32'(acc1), 32'(16'hFFFC));

    // clear together with accumulate, then non-acc op keeps acc
    issue(2'b10, 16'h0010, 16'h0000, 1, 16'h0010, 0, 16'h0010, 0, t);
    chk("acc_10", 32'(acc0), 32'(16'h0010));
    issue(2'b00, 16'h7FFF, 16'h0001, 0, 16'h8000, 1, 16'h7FFF, 1, t);
    chk("acc_keep", 32'(acc0), 32'(16'h0010));
    chk("stk_set", 32'(stk0), 32'(1));
    issue(2'b10, 16'h0002, 16'h0000, 1, 16'h0002, 0, 16'h0002, 0, t);
    chk("clrop_acc", 32'(acc0), 32'(16'h0002));
    chk("clrop_stk", 32'(stk0), 32'(0));

    // accumulator overflow: wrap and saturate paths diverge
    issue(2'b10, 16'h7FFF, 16'h0000, 1, 16'h7FFF, 0, 16'h7FFF, 0, t);
    issue(2'b10, 16'h0001, 16'h0000, 0, 16'h8000, 1, 16'h7FFF, 1, t);
    chk("acc0_wrap", 32'(acc0), 32'(16'h8000));
    chk("acc1_sat", 32'(acc1), 32'(16'h7FFF));
    issue(2'b11, 16'h0001, 16'h0000, 0, 16'h7FFF, 1, 16'h7FFE, 0, t);
    chk("acc0_sub", 32'(acc0), 32'(16'h7FFF));
    chk("acc1_sub", 32'(acc1), 32'(16'h7FFE));
    chk("stk1_acc", 32'(stk1), 32'(1));
    idle();

    // backpressure
    out_ready = 1'b0;
    issue(2'b00, 16'h0100, 16'h0001, 0, 16'h0101, 0, 16'h0101, 0, t);
    op = 2'b00;
    A = 16'h0200;
    B = 16'h0002;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rdy", 32'(in_ready0), 32'(0));
      chk("bp_ov", 32'(ov0), 32'(1));
      chk("bp_res", 32'(res0), 32'(16'h0101));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(2'b00, 16'h0200, 16'h0002, 0, 16'h0202, 0, 16'h0202, 0, t);
    chk("bp_release", 32'(t), 32'(1));
    for (int i = 1; i <= 8; i++) begin
      a = 16'(i * 16'h0300);
      issue(2'b01, a, 16'(i), 0, a - 16'(i), 0, a - 16'(i), 0, t);
      chk("stream_thru", 32'(t), 32'(1));
    end
    idle();
    idle();
    chk("bp_q0", 32'(q0.size()), 32'(0));
    chk("bp_pop", 32'(popped0), 32'(pushed));

    // reset with a held result in flight
    issue(2'b10, 16'h1234, 16'h0000, 1, 16'h1234, 0, 16'h1234, 0, t);
    idle();
    out_ready = 1'b0;
    issue(2'b00, 16'h7FFF, 16'h0001, 0, 16'h8000, 1, 16'h7FFF, 1, t);
    idle();
    chk("pre_ov", 32'(ov0), 32'(1));
    chk("pre_acc", 32'(acc0), 32'(16'h1234));
    chk("pre_stk", 32'(stk0), 32'(1));
    rst_n = 1'b0;
    in_valid = 1'b1;
    op = 2'b00;
    A = 16'h0055;
    B = 16'h0000;
    @(negedge clk);
    chk("inrst_rdy", 32'(in_ready0), 32'(1));
    @(posedge clk);
    #1;
    chk("mrst_ov", 32'(ov0), 32'(0));
    chk("mrst_ov1", 32'(ov1), 32'(0));
    chk("mrst_acc", 32'(acc0), 32'(0));
    chk("mrst_stk", 32'(stk0), 32'(0));
    chk("mrst_res", 32'(res0), 32'(0));
    chk("mrst_q", 32'(q0.size()), 32'(1));
    q0.delete();
    q1.delete();
    in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(2'b00, 16'h0001, 16'h0002, 0, 16'h0003, 0, 16'h0003, 0, t);
    chk("post_rst", 32'(t), 32'(1));
    idle();
    idle();
    chk("end_q0", 32'(q0.size()), 32'(0));
    chk("end_q1", 32'(q1.size()), 32'(0));
    chk("end_pop0", 32'(popped0), 32'(pushed - 1));
    chk("end_pop1", 32'(popped1), 32'(pushed - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
